// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_if
// Brief   : Load/ack handshake and display drive signals for seg_scan_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface seg_scan_if;
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  logic [3:0]  disp_en;
  logic        load;
  logic        load_ack;
  logic        frame_start;
  logic [7:0]  duan_ma;
  logic [3:0]  wei_ma;

  modport master (
    output disp_data, disp_dp, disp_en, load,
    input  load_ack, frame_start, duan_ma, wei_ma
  );

  modport slave (
    input  disp_data, disp_dp, disp_en, load,
    output load_ack, frame_start, duan_ma, wei_ma
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : 4-digit common-anode 7-segment scanner with blanking gaps and
//           frame-aligned load/ack content updates.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic      clk_50M,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             live_q;
  logic [15:0]      data_q, data_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       en_q, en_d;
  logic             ack_q, ack_d;
  logic             fs_q, fs_d;
  logic [7:0]       duan_q, duan_d;
  logic [3:0]       wei_q, wei_d;
  logic [3:0]       nib;
  logic [6:0]       seg;
  logic             boundary;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_ONE;
    data_d   = data_q;
    dp_d     = dp_q;
    en_d     = en_q;
    ack_d    = 1'b0;
    nib      = 4'h0;
    seg      = 7'h7F;
    wei_d    = 4'hF;
    duan_d   = 8'hFF;
    boundary = (state_q == SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);

    // live_q low means the previous edge was in reset: start digit 0 blank fresh
    if (!live_q) begin
      state_d = BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else if (cnt_q == SHOW_LAST) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
    end

    if (boundary && bus.load) begin
      data_d = bus.disp_data;
      dp_d   = bus.disp_dp;
      en_d   = bus.disp_en;
      ack_d  = 1'b1;
    end

    fs_d = (state_d == BLANK) && (idx_d == 2'd0) && (cnt_d == '0);

    nib = data_d[{idx_d, 2'b00} +: 4];
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase

    // Outputs are decoded from next state so they change on the same edge as it
    if (state_d == SHOW) begin
      duan_d = {~dp_d[idx_d], seg};
      if (en_d[idx_d]) begin
        wei_d = ~(4'b0001 << idx_d);
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      data_q  <= 16'h0000;
      dp_q    <= 4'h0;
      en_q    <= 4'h0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
      duan_q  <= 8'hFF;
      wei_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      data_q  <= data_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
      duan_q  <= duan_d;
      wei_q   <= wei_d;
    end
  end

  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;
  assign bus.duan_ma     = duan_q;
  assign bus.wei_ma      = wei_q;

endmodule
`default_nettype wire
